shot_scheduler: RTL and testbench

//  Owns the pool of player shot slots fired from the player sprite. Allocates a free slot on fire

---
 rtl/shot_scheduler.sv | 109 ++++++++++
 tb/tb_shot_scheduler.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shot_scheduler.sv
// Player shot slot pool: rate-limited allocation on fire, upward motion per tick,
// retirement on leaving the top of the screen or on a collision report.
module shot_scheduler #(
  parameter int NSLOT    = 4,
  parameter int COOLDOWN = 8,
  parameter int SPEED    = 4,
  parameter int XOFF     = 20
) (
  input  logic                  clk22,
  input  logic                  rst_n,
  input  logic                  gameover,
  input  logic                  fire,
  input  logic                  tick,
  input  logic [9:0]            reimux,
  input  logic [9:0]            reimuy,
  input  logic                  hit_valid,
  input  logic [2:0]            hit_slot,
  output logic [NSLOT-1:0]      shot_valid,
  output logic [10*NSLOT-1:0]   shot_x,
  output logic [10*NSLOT-1:0]   shot_y,
  output logic                  fire_ack,
  output logic                  pool_full
);

  logic [NSLOT-1:0]       valid_q, valid_d;
  logic [NSLOT-1:0][9:0]  x_q, x_d;
  logic [NSLOT-1:0][9:0]  y_q, y_d;
  logic [7:0]             cd_q, cd_d;
  logic                   ack_q, ack_d;
  logic [NSLOT-1:0]       hit_vec;
  logic                   alloc_ok;
  logic                   found;

  assign shot_valid = valid_q;
  assign shot_x     = x_q;
  assign shot_y     = y_q;
  assign fire_ack   = ack_q;
  assign pool_full  = &valid_q;

  // Allocation looks only at registered valids, so a slot freed this cycle is reusable next cycle.
  assign alloc_ok = fire && (cd_q == 8'd0) && !pool_full;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    valid_d = valid_q;
    x_d     = x_q;
    y_d     = y_q;
    ack_d   = 1'b0;
    cd_d    = (cd_q != 8'd0) ? cd_q - 8'd1 : cd_q;
    hit_vec = '0;
    found   = 1'b0;

    for (int i = 0; i < NSLOT; i++) begin
      if (hit_valid && (hit_slot == 3'(i)))
        hit_vec[i] = 1'b1;
    end

    if (gameover) begin
      valid_d = '0;
      x_d     = '0;
      y_d     = '0;
      cd_d    = 8'd0;
    end else begin
      for (int i = 0; i < NSLOT; i++) begin
        if (hit_vec[i]) begin
          valid_d[i] = 1'b0;
        end else if (tick && valid_q[i]) begin
          if (y_q[i] < 10'(SPEED))
            valid_d[i] = 1'b0;
          else
            y_d[i] = y_q[i] - 10'(SPEED);
        end
      end

      // Free slots are dead in valid_q, so neither tick nor hit touches the one allocated here.
      if (alloc_ok) begin
        for (int i = 0; i < NSLOT; i++) begin
          if (!found && !valid_q[i]) begin
            found      = 1'b1;
            valid_d[i] = 1'b1;
            x_d[i]     = reimux + 10'(XOFF);
            y_d[i]     = reimuy;
          end
        end
        ack_d = 1'b1;
        cd_d  = 8'(COOLDOWN);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk22 or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: slot coordinates are reset too, since they are visible outputs with defined reset values.
      valid_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      cd_q    <= 8'd0;
      ack_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cd_q    <= cd_d;
      ack_q   <= ack_d;
    end
  end

endmodule

// File: tb/tb_shot_scheduler.sv
// Directed bench for shot_scheduler: reset, allocation, cooldown, motion, hit, pool full, gameover.
module tb_shot_scheduler;

  localparam int NSLOT = 4;

  logic                clk22 = 1'b0;
  logic                rst_n, gameover, fire, tick, hit_valid;
  logic [9:0]          reimux, reimuy;
  logic [2:0]          hit_slot;
  logic [NSLOT-1:0]    shot_valid;
  logic [10*NSLOT-1:0] shot_x, shot_y;
  logic                fire_ack, pool_full;

  int checks = 0;
  int errors = 0;

  shot_scheduler #(.NSLOT(NSLOT), .COOLDOWN(8), .SPEED(4), .XOFF(20)) dut (
    .clk22(clk22), .rst_n(rst_n), .gameover(gameover), .fire(fire), .tick(tick),
    .reimux(reimux), .reimuy(reimuy), .hit_valid(hit_valid), .hit_slot(hit_slot),
    .shot_valid(shot_valid), .shot_x(shot_x), .shot_y(shot_y),
    .fire_ack(fire_ack), .pool_full(pool_full)
  );

  always #5 clk22 = ~clk22;

  task automatic step();
    @(posedge clk22);
    #1;
  endtask

  task automatic clear_pool();
    gameover = 1'b1;
    step();
    gameover = 1'b0;
  endtask

  // Holds fire until an ack appears; a missing ack within the bound counts as a failure.
  task automatic fire_until_ack(input logic [9:0] px, input logic [9:0] py);
    bit got = 0;
    reimux = px;
    reimuy = py;
    fire   = 1'b1;
    for (int n = 0; n < 20 && !got; n++) begin
      step();
      if (fire_ack) got = 1;
    end
    fire = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL fire_until_ack: no ack within 20 cycles, got none, expected one");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if (shot_valid !== 4'b0000 || fire_ack !== 1'b0 || pool_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: valid=%b ack=%b full=%b expected 0000 0 0", shot_valid, fire_ack, pool_full);
    end
    checks++;
    if (shot_x !== 40'd0 || shot_y !== 40'd0) begin
      errors++;
      $display("FAIL reset_coords: x=%h y=%h expected 0 0", shot_x, shot_y);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_fire();
    reimux = 10'd100;
    reimuy = 10'd400;
    fire   = 1'b1;
    step();
    fire = 1'b0;
    checks++;
    if (shot_valid !== 4'b0001 || fire_ack !== 1'b1) begin
      errors++;
      $display("FAIL single_fire_valid: valid=%b ack=%b expected 0001 1", shot_valid, fire_ack);
    end
    checks++;
    if (shot_x[9:0] !== 10'd120 || shot_y[9:0] !== 10'd400) begin
      errors++;
      $display("FAIL single_fire_pos: x0=%0d y0=%0d expected 120 400", shot_x[9:0], shot_y[9:0]);
    end
    step();
    checks++;
    if (fire_ack !== 1'b0) begin
      errors++;
      $display("FAIL single_fire_pulse: ack=%b expected 0", fire_ack);
    end
  endtask

  task automatic test_fire_held();
    int ack_cyc[$];
    int exp_cyc[4] = '{1, 10, 19, 28};
    clear_pool();
    reimux = 10'd50;
    reimuy = 10'd300;
    fire   = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (fire_ack) ack_cyc.push_back(c);
    end
    fire = 1'b0;
    checks++;
    if (ack_cyc.size() != 4) begin
      errors++;
      $display("FAIL fire_held_count: acks=%0d expected 4", ack_cyc.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (ack_cyc[k] != exp_cyc[k]) begin
          errors++;
          $display("FAIL fire_held_cycle%0d: ack at %0d expected %0d", k, ack_cyc[k], exp_cyc[k]);
        end
      end
    end
    checks++;
    if (pool_full !== 1'b1 || shot_valid !== 4'b1111) begin
      errors++;
      $display("FAIL fire_held_full: full=%b valid=%b expected 1 1111", pool_full, shot_valid);
    end
  endtask

  task automatic test_motion();
    logic [9:0] exp_y[3] = '{10'd6, 10'd2, 10'd2};
    logic       exp_v[3] = '{1'b1, 1'b1, 1'b0};
    clear_pool();
    fire_until_ack(10'd0, 10'd10);
    for (int k = 0; k < 3; k++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      checks++;
      if (shot_valid[0] !== exp_v[k] || shot_y[9:0] !== exp_y[k] || shot_x[9:0] !== 10'd20) begin
        errors++;
        $display("FAIL motion_tick%0d: v=%b y=%0d x=%0d expected %b %0d 20",
                 k, shot_valid[0], shot_y[9:0], shot_x[9:0], exp_v[k], exp_y[k]);
      end
    end
  endtask

  task automatic test_hit_tick();
    clear_pool();
    fire_until_ack(10'd10, 10'd100);
    fire_until_ack(10'd30, 10'd200);
    hit_valid = 1'b1;
    hit_slot  = 3'd0;
    tick      = 1'b1;
    step();
    tick = 1'b0;
    checks++;
    if (shot_valid !== 4'b0010 || shot_y[9:0] !== 10'd100 || shot_y[19:10] !== 10'd196) begin
      errors++;
      $display("FAIL hit_tick: valid=%b y0=%0d y1=%0d expected 0010 100 196",
               shot_valid, shot_y[9:0], shot_y[19:10]);
    end
    hit_slot = 3'd5;
    step();
    hit_slot = 3'd0;
    step();
    hit_valid = 1'b0;
    checks++;
    if (shot_valid !== 4'b0010) begin
      errors++;
      $display("FAIL hit_ignored: valid=%b expected 0010", shot_valid);
    end
  endtask

  task automatic test_full_hit_fire();
    clear_pool();
    fire_until_ack(10'd0, 10'd100);
    fire_until_ack(10'd0, 10'd110);
    fire_until_ack(10'd0, 10'd120);
    fire_until_ack(10'd0, 10'd130);
    for (int n = 0; n < 9; n++) step();
    checks++;
    if (pool_full !== 1'b1) begin
      errors++;
      $display("FAIL full_before: full=%b expected 1", pool_full);
    end
    hit_valid = 1'b1;
    hit_slot  = 3'd2;
    fire      = 1'b1;
    reimuy    = 10'd300;
    step();
    hit_valid = 1'b0;
    checks++;
    if (shot_valid !== 4'b1011 || fire_ack !== 1'b0) begin
      errors++;
      $display("FAIL full_hit_fire: valid=%b ack=%b expected 1011 0", shot_valid, fire_ack);
    end
    step();
    fire = 1'b0;
    checks++;
    if (shot_valid !== 4'b1111 || fire_ack !== 1'b1 || shot_y[29:20] !== 10'd300) begin
      errors++;
      $display("FAIL refill_slot2: valid=%b ack=%b y2=%0d expected 1111 1 300",
               shot_valid, fire_ack, shot_y[29:20]);
    end
  endtask

  task automatic test_gameover();
    clear_pool();
    fire_until_ack(10'd0, 10'd100);
    fire_until_ack(10'd0, 10'd110);
    fire_until_ack(10'd0, 10'd120);
    gameover = 1'b1;
    fire     = 1'b1;
    step();
    gameover = 1'b0;
    checks++;
    if (shot_valid !== 4'b0000 || fire_ack !== 1'b0 || shot_y !== 40'd0) begin
      errors++;
      $display("FAIL gameover_clear: valid=%b ack=%b y=%h expected 0000 0 0", shot_valid, fire_ack, shot_y);
    end
    reimuy = 10'd77;
    step();
    fire = 1'b0;
    checks++;
    if (shot_valid !== 4'b0001 || fire_ack !== 1'b1 || shot_y[9:0] !== 10'd77) begin
      errors++;
      $display("FAIL gameover_refire: valid=%b ack=%b y0=%0d expected 0001 1 77",
               shot_valid, fire_ack, shot_y[9:0]);
    end
    fire_until_ack(10'd0, 10'd90);
    fire_until_ack(10'd0, 10'd95);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (shot_valid !== 4'b0000 || fire_ack !== 1'b0 || shot_x !== 40'd0) begin
      errors++;
      $display("FAIL async_reset: valid=%b ack=%b x=%h expected 0000 0 0", shot_valid, fire_ack, shot_x);
    end
    #1;
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b0; gameover = 1'b0; fire = 1'b0; tick = 1'b0;
    reimux = '0; reimuy = '0; hit_valid = 1'b0; hit_slot = '0;
    test_reset();
    test_single_fire();
    test_fire_held();
    test_motion();
    test_hit_tick();
    test_full_hit_fire();
    test_gameover();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
